// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bus master with byte lanes,
// bounded ack wait and a registered load result.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] memory_value,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, mv_q, mv_d;
    logic        lb_q, lb_d, sb_q, sb_d, we_q, we_d, err_q, err_d;
    logic        req, tmo, in_busy, byte_acc;
    logic [7:0]  rbyte;
    assign req      = mem_read | mem_write;
    // Timeout fires on the TIMEOUT-th BUSY cycle; ack in that cycle still wins.
    assign tmo      = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);
    assign rbyte    = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign in_busy  = state_q == BUSY;
    assign byte_acc = we_q ? sb_q : lb_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lb_d    = lb_q;
        sb_d    = sb_q;
        we_d    = we_q;
        err_d   = err_q;
        mv_d    = mv_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                cnt_d   = '0;
                err_d   = 1'b0;
                addr_d  = address;
                data_d  = store_data;
                lb_d    = load_byte;
                sb_d    = store_byte;
                we_d    = mem_write;
            end
            BUSY: if (bus_ack) begin
                state_d = DONE;
                if (!we_q) mv_d = lb_q ? {24'b0, rbyte} : bus_rdata;
            end else if (tmo) begin
                state_d = DONE;
                err_d   = 1'b1;
                if (!we_q) mv_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lb_q    <= 1'b0;
            sb_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mv_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lb_q    <= lb_d;
            sb_q    <= sb_d;
            we_q    <= we_d;
            err_q   <= err_d;
            mv_q    <= mv_d;
        end
    end
    assign bus_req      = in_busy;
    assign bus_we       = in_busy & we_q;
    assign bus_addr     = in_busy ? {addr_q[31:2], 2'b00} : '0;
    assign bus_sel      = in_busy ? (byte_acc ? 4'b0001 << addr_q[1:0] : 4'hF) : 4'h0;
    assign bus_wdata    = in_busy ? ((we_q & sb_q) ? {4{data_q[7:0]}} : data_q) : '0;
    assign memory_value = mv_q;
    assign busy         = ((state_q == IDLE) & req) | in_busy;
    assign done         = state_q == DONE;
    assign error        = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench; driver issues accesses and
// queues expectations, a negedge monitor checks bus phases and completions.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_read = 0, mem_write = 0, load_byte = 0, store_byte = 0;
    logic [31:0] address = 0, store_data = 0, bus_rdata = 0;
    logic        bus_ack = 0;
    logic        bus_req, bus_we, busy, done, error;
    logic [31:0] bus_addr, bus_wdata, memory_value;
    logic [3:0]  bus_sel;
    int vec = 0, errs = 0;
    localparam int NEVER = 255;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] mv;
        logic        err;
    } exp_t;
    exp_t sb[$];
    logic [31:0] mv_model = 0;
    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .load_byte(load_byte), .store_byte(store_byte), .address(address),
        .store_data(store_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .memory_value(memory_value),
        .busy(busy), .done(done), .error(error)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (!rst) begin
        if (bus_req) begin
            vec++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL bus_phase: bus_req=1 with no outstanding access");
            end else if (!(busy && bus_we == sb[0].we && bus_addr == sb[0].addr &&
                           bus_sel == sb[0].sel && (!sb[0].we || bus_wdata == sb[0].wdata))) begin
                errs++;
                $display("FAIL bus_phase: got busy=%b we=%b addr=%h sel=%b wdata=%h, want busy=1 we=%b addr=%h sel=%b wdata=%h",
                         busy, bus_we, bus_addr, bus_sel, bus_wdata,
                         sb[0].we, sb[0].addr, sb[0].sel, sb[0].wdata);
            end
        end
        if (done) begin
            vec++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL done_pulse: done=1 with no outstanding access");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (!(error == e.err && memory_value == e.mv && !bus_req && !busy)) begin
                    errs++;
                    $display("FAIL completion: got error=%b mv=%h req=%b busy=%b, want error=%b mv=%h req=0 busy=0",
                             error, memory_value, bus_req, busy, e.err, e.mv);
                end
            end
        end
    end
    task automatic run(input logic rd, input logic wr, input logic lb, input logic sbt,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                       input int delay, input logic hold);
        exp_t e;
        logic [31:0] byte_val;
        bit got;
        e.we    = wr;
        e.addr  = {a[31:2], 2'b00};
        e.sel   = (wr ? sbt : lb) ? 4'b0001 << a[1:0] : 4'hF;
        e.wdata = sbt ? {4{sd[7:0]}} : sd;
        e.err   = delay >= NEVER;
        byte_val = (rdat >> (8 * a[1:0])) & 32'hFF;
        if (!wr) mv_model = e.err ? 32'h0 : (lb ? byte_val : rdat);
        e.mv = mv_model;
        @(negedge clk);
        mem_read = rd; mem_write = wr; load_byte = lb; store_byte = sbt;
        address = a; store_data = sd;
        sb.push_back(e);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        address = $urandom; store_data = $urandom; load_byte = $urandom; store_byte = $urandom;
        if (delay < NEVER) begin
            repeat (delay) @(negedge clk);
            bus_ack = 1; bus_rdata = rdat;
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) begin
            vec++; errs++;
            $display("FAIL done_timeout: got no done within 300 cycles, want done");
            sb.delete();
        end
        if (hold) @(negedge clk);
        bus_ack = 0;
    endtask
    initial begin
        #2;
        vec++;
        if ({bus_req, bus_we, done, error, busy, bus_sel, bus_addr, bus_wdata, memory_value} != '0) begin
            errs++;
            $display("FAIL reset_state: got req=%b we=%b done=%b err=%b busy=%b sel=%b addr=%h wdata=%h mv=%h, want all 0",
                     bus_req, bus_we, done, error, busy, bus_sel, bus_addr, bus_wdata, memory_value);
        end
        @(negedge clk); @(negedge clk);
        rst = 0;
        run(1, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
        run(1, 0, 1, 0, 32'h203, 32'h0, 32'h11223344, 1, 0);
        run(0, 1, 0, 1, 32'h301, 32'hABCD12EF, 32'h55555555, 0, 1);
        run(1, 0, 0, 0, 32'h400, 32'h0, 32'hCAFEF00D, NEVER, 0);
        run(1, 0, 0, 0, 32'h404, 32'h0, 32'h12345678, 0, 0);
        run(1, 1, 0, 0, 32'h500, 32'h87654321, 32'hFFFFFFFF, 254, 0);
        run(0, 1, 0, 0, 32'h600, 32'h0BADF00D, 32'h0, NEVER, 1);
        begin
            exp_t e;
            e.we = 0; e.addr = 32'h700; e.sel = 4'hF; e.wdata = 0; e.mv = 0; e.err = 0;
            @(negedge clk);
            mem_read = 1; address = 32'h700;
            sb.push_back(e);
            @(negedge clk);
            mem_read = 0;
            @(negedge clk);
            @(posedge clk); #2 rst = 1;
            #1;
            vec++;
            if (bus_req || busy || done || error || memory_value != 0) begin
                errs++;
                $display("FAIL mid_busy_reset: got req=%b busy=%b done=%b err=%b mv=%h, want all 0",
                         bus_req, busy, done, error, memory_value);
            end
            void'(sb.pop_front());
            mv_model = 0;
            @(negedge clk);
            @(negedge clk);
            rst = 0; bus_ack = 1; bus_rdata = 32'hA5A5A5A5;
            repeat (3) @(negedge clk);
            vec++;
            if (bus_req || done || memory_value != 0) begin
                errs++;
                $display("FAIL late_ack: got req=%b done=%b mv=%h, want 0 0 0", bus_req, done, memory_value);
            end
            bus_ack = 0;
        end
        for (int n = 0; n < 60; n++) begin
            int r, d;
            logic rd, wr;
            r = $urandom_range(0, 19);
            d = r < 16 ? $urandom_range(0, 4) : (r < 18 ? 254 : NEVER);
            r = $urandom_range(0, 2);
            rd = r != 1; wr = r != 0;
            run(rd, wr, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, d, 1'($urandom));
        end
        repeat (3) @(negedge clk);
        vec++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with the ports listed below (clock and reset first).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  core load request
- mem_write  in  1  core store request
- load_byte  in  1  load is a byte load
- store_byte  in  1  store is a byte store
- address  in  32  byte address of the access
- store_data  in  32  store source; the byte store uses [7:0]
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write strobe qualifying bus_req
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_wdata  out  32  write data
- bus_sel  out  4  byte-lane enables
- bus_ack  in  1  bus completion
- bus_rdata  in  32  read data, valid when bus_ack is high
- memory_value  out  32  registered load result, fed to the register-file write mux
- busy  out  1  core stall request
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle timeout pulse
REQ-002 Parameter: TIMEOUT, default 255; this is the maximum number of cycles the unit waits for bus_ack.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-004 In IDLE, if (mem_read | mem_write) is high at a clock edge, the unit SHALL latch address, store_data, load_byte, store_byte and the direction, then enter BUSY.
REQ-005 If mem_read and mem_write are both high in IDLE, the unit SHALL treat the request as a write.
REQ-006 While in BUSY: bus_req=1, bus_we equals the latched direction, and bus_addr, bus_wdata and bus_sel are driven from the latched values and SHALL NOT change.
REQ-007 Word access: bus_sel=4'b1111 and bus_wdata=store_data.
REQ-008 Byte access: bus_sel=4'b0001<<addr[1:0]; for stores, bus_wdata={4{store_data[7:0]}}.
REQ-009 In BUSY with bus_ack=1, the unit SHALL enter DONE at the next edge. On a read, memory_value SHALL capture bus_rdata for a word load, or {24'b0, byte addr[1:0] of bus_rdata} for a byte load.
REQ-010 A 8-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle. When it reaches TIMEOUT with bus_ack=0, the unit SHALL enter DONE with error flagged, and memory_value SHALL load 0 if the access is a read.
REQ-011 If bus_ack=1 in the same cycle the timeout is reached, the ack SHALL win and no error is reported.
REQ-012 In DONE: done=1 for exactly one cycle, error=1 only on a timeout, bus_req=0; the state returns to IDLE next cycle unconditionally.
REQ-013 mem_read and mem_write SHALL be ignored while in BUSY and DONE, so no request is re-issued in DONE.
REQ-014 busy SHALL be combinational: (IDLE & (mem_read|mem_write)) | BUSY. busy SHALL be 0 in DONE so the core advances on that edge.
REQ-015 Store completion SHALL NOT modify memory_value; memory_value holds its value until the next completed load.
REQ-016 bus_ack SHALL be ignored in IDLE and DONE.
REQ-017 Minimum request-to-done latency is 2 cycles (accept edge, ack cycle); every access occupies at least one DONE cycle.

Reset
REQ-018 rst=1 SHALL force the IDLE state immediately and asynchronously, dropping bus_req within the same cycle.
REQ-019 Reset values: memory_value=0, counter=0, all latched fields 0, bus_req=bus_we=done=error=0, bus_sel=0, bus_addr=bus_wdata=0.
REQ-020 A reset that arrives while in BUSY SHALL abandon the access with no done or error pulse; a late bus_ack after reset SHALL be ignored.

Verification
REQ-021 Word load: address=0x100, mem_read=1, bus_ack after 3 cycles with bus_rdata=0xDEADBEEF -> bus_sel=4'hF, bus_addr=0x100, then done pulse, memory_value=0xDEADBEEF.
REQ-022 Byte load: address=0x203, load_byte=1, bus_rdata=0x11223344 -> bus_sel=4'b1000, bus_addr=0x200, memory_value=0x00000011.
REQ-023 Byte store: address=0x301, store_byte=1, store_data=0xABCD12EF -> bus_we=1, bus_sel=4'b0010, bus_wdata=0xEFEFEFEF; memory_value unchanged.
REQ-024 Timeout: read with bus_ack held at 0 -> after 255 BUSY cycles, error=1 and done=1 in the same cycle, memory_value=0, bus_req=0.
REQ-025 Simultaneous events: mem_read=mem_write=1 issues a write; bus_ack arriving on cycle 255 gives done=1 with error=0.
REQ-026 rst asserted mid-BUSY -> bus_req=0 in the same cycle, no done pulse; bus_ack=1 afterwards leaves the unit in IDLE.
